// File: rtl/bitwise_pkg.sv
// Shared constants for the bitwise logic pipe: op codes and default widths.
package bitwise_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_NOT_A  = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational bitwise operation with zero and parity flags on the result.
module bitwise_op_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_eff,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = a_eff & b;
      OP_OR:     result = a_eff | b;
      OP_XOR:    result = a_eff ^ b;
      OP_NAND:   result = ~(a_eff & b);
      OP_NOR:    result = ~(a_eff | b);
      OP_XNOR:   result = ~(a_eff ^ b);
      OP_NOT_A:  result = ~a_eff;
      OP_PASS_A: result = a_eff;
      default:   result = '0;
    endcase
  end

  assign zero   = (result == '0);
  assign parity = ^result;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and saturating op counter.
// Optional accumulator chaining is compiled in with BITWISE_ACC_EN.
module bitwise_logic_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] result;
  logic             res_zero;
  logic             res_parity;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef BITWISE_ACC_EN
  logic [WIDTH-1:0] acc;

  // A same-cycle clear takes effect before the accumulator is used as operand A.
  assign a_eff = acc_sel ? (acc_clr ? '0 : acc) : a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end
`else
  logic unused_acc_ports;

  assign unused_acc_ports = acc_sel | acc_clr;
  assign a_eff            = a;
`endif

  bitwise_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .a_eff  (a_eff),
    .b      (b),
    .result (result),
    .zero   (res_zero),
    .parity (res_parity)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= result;
      zero      <= res_zero;
      parity    <= res_parity;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed table, accumulator and reset
// sequences, then randomized traffic against a truth-table reference model.
module tb_bitwise_logic_pipe;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] op_count;

  int ntests = 0;
  int nfail  = 0;

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_y;
  logic             m_zero;
  logic             m_par;
  int               m_count;
  logic [WIDTH-1:0] m_acc;

  // per-op truth table indexed by {a_bit, b_bit}
  logic [3:0] tt [8];

  bitwise_logic_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_sel   (acc_sel),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ordy;
    logic       valid;
    logic [7:0] y;
    logic       zero;
    logic       par;
    int         cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    logic [3:0]       t;
    t = tt[o];
    for (int i = 0; i < WIDTH; i++) r[i] = t[{x[i], z[i]}];
    return r;
  endfunction

  function automatic logic ones_odd(input logic [WIDTH-1:0] v);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return (n % 2) == 1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = '0;
    m_zero  = 1'b0;
    m_par   = 1'b0;
    m_count = 0;
    m_acc   = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, m_valid);
    chk({tag, "_y"}, y, m_y);
    chk({tag, "_zero"}, zero, m_zero);
    chk({tag, "_parity"}, parity, m_par);
    chk({tag, "_op_count"}, op_count, m_count);
  endtask

  // Called at a falling edge: drive, check in_ready, advance model, clock once.
  task automatic step(input logic iv, input logic [2:0] iop, input logic [7:0] ia,
                      input logic [7:0] ib, input logic ordy, input logic asel,
                      input logic aclr, input string tag);
    logic             acc_m;
    logic [WIDTH-1:0] aeff;
    logic [WIDTH-1:0] r;
    in_valid  = iv;
    op        = iop;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    acc_sel   = asel;
    acc_clr   = aclr;
    #1;
    chk({tag, "_in_ready"}, in_ready, !m_valid || ordy);
    acc_m = iv && (!m_valid || ordy);
    aeff  = ia;
`ifdef BITWISE_ACC_EN
    if (asel) aeff = aclr ? '0 : m_acc;
`endif
    r = ref_op(iop, aeff, ib);
    if (acc_m) begin
      m_valid = 1'b1;
      m_y     = r;
      m_zero  = (r == '0);
      m_par   = ones_odd(r);
      if (m_count < CNT_MAX) m_count++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
`ifdef BITWISE_ACC_EN
    if (acc_m) m_acc = r;
    else if (aclr) m_acc = '0;
`endif
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0110;  // XOR
    tt[3] = 4'b0111;  // NAND
    tt[4] = 4'b0001;  // NOR
    tt[5] = 4'b1001;  // XNOR
    tt[6] = 4'b0011;  // NOT A
    tt[7] = 4'b1100;  // PASS A

    vecs[0]  = '{1'b1, 3'd1, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[2]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 2};
    vecs[7]  = '{1'b1, 3'd0, 8'hAA, 8'h0F, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b1, 3'd2, 8'hAA, 8'h0F, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 4};
    vecs[9]  = '{1'b1, 3'd4, 8'hAA, 8'h0F, 1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 5};
    vecs[10] = '{1'b1, 3'd6, 8'hAA, 8'h0F, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 6};
    vecs[11] = '{1'b1, 3'd2, 8'h5A, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 7};
    vecs[12] = '{1'b1, 3'd7, 8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 8};
    vecs[13] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    acc_sel   = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].iv, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ordy, 1'b0, 1'b0,
           $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_valid", i), out_valid, vecs[i].valid);
      chk($sformatf("tbl%0d_exp_y", i), y, vecs[i].y);
      chk($sformatf("tbl%0d_exp_zero", i), zero, vecs[i].zero);
      chk($sformatf("tbl%0d_exp_parity", i), parity, vecs[i].par);
      chk($sformatf("tbl%0d_exp_count", i), op_count, vecs[i].cnt);
    end

`ifdef BITWISE_ACC_EN
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "acc_clr");
    step(1'b1, 3'd1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, "acc1");
    chk("acc1_exp_y", y, 8'h01);
    step(1'b1, 3'd1, 8'hFF, 8'h02, 1'b1, 1'b1, 1'b0, "acc2");
    chk("acc2_exp_y", y, 8'h03);
    step(1'b1, 3'd1, 8'hFF, 8'h04, 1'b1, 1'b1, 1'b0, "acc3");
    chk("acc3_exp_y", y, 8'h07);
    step(1'b1, 3'd1, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1, "acc_clr_accept");
    chk("acc_clr_accept_exp_y", y, 8'h80);
    step(1'b1, 3'd1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, "acc_after_clr");
    chk("acc_after_clr_exp_y", y, 8'h81);
`endif

    // counter saturation
    for (int i = 0; i < 20; i++)
      step(1'b1, 3'd7, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, "sat");
    chk("sat_exp_count", op_count, CNT_MAX);

    // async reset while a result is pending (and acc holds a nonzero value)
    step(1'b1, 3'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, "pre_rst");
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_in_ready", in_ready, 1'b1);
    check_outputs("mid_rst");
    #1;
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 3'd1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, "post_rst");
    chk("post_rst_exp_count", op_count, 1);
`ifdef BITWISE_ACC_EN
    chk("post_rst_acc_zero", y, 8'h00);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, "rnd");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, registered bitwise logic unit. Applies one of eight bitwise operations to two WIDTH-bit operands under a valid/ready handshake and returns a registered result with zero and parity flags. An optional accumulator mode chains results: each new operation can use the previous result as operand A. The block sits between operand sources and downstream consumers in the datapath, alongside the combinational gate blocks.

## Interface
- WIDTH, 8: operand/result width in bits (≥1)
- CNT_W, 16: width of the accepted-operation counter

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set this cycle
- op  in  3  operation select, sampled on accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc_sel  in  1  use accumulator as operand A (only with BITWISE_ACC_EN)
- acc_clr  in  1  synchronous accumulator clear (only with BITWISE_ACC_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- zero  out  1  y == 0
- parity  out  1  XOR-reduction of y
- op_count  out  CNT_W  number of accepted operand sets, saturating

## Operation
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A.
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready.
- On accept: y, zero and parity load from the computed result; out_valid sets; op_count increments, holding at all-ones.
- On out_valid && out_ready with no accept: out_valid clears; y and flags hold their last values.
- Accept and output handshake in the same cycle: new result replaces the old one, out_valid stays 1. This gives full throughput with no bubble.
- Inputs are ignored when not accepted. Output holds stable while out_valid && !out_ready.
- Accumulator (BITWISE_ACC_EN):
  - Internal register acc, WIDTH bits.
  - If acc_sel, operand A is acc instead of a.
  - On every accept, acc loads the result, whatever acc_sel is.
  - acc_clr with no accept: acc ← 0.
  - acc_clr together with an accept: operand A for that operation is 0 if acc_sel, and acc loads the result (clear applies first).

## Timing
- Latency 1 cycle from accept to out_valid.
- Throughput 1 result per cycle while out_ready stays high.
- Reset values: out_valid 0, y 0, zero 0, parity 0, op_count 0, acc 0. in_ready reads 1 during and after reset.
- Reset asserted mid-transfer drops any pending result. No output handshake completes for it.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.

## Configuration
- BITWISE_ACC_EN defined: acc register and the acc_sel/acc_clr behaviour are compiled in.
- BITWISE_ACC_EN undefined:
  - acc_sel and acc_clr remain as ports but are ignored.
  - Operand A is always a.
  - No acc register is synthesised.

## Structure
- Shared package bitwise_pkg holds:
  - op code constants OP_AND … OP_PASS_A (3 bits);
  - default WIDTH and CNT_W.
- One sub-module, bitwise_op_core:
  - combinational and parametrised by WIDTH;
  - inputs op, a_eff, b; outputs result, zero, parity.
- The top level holds the handshake register, the counter and the accumulator.

## Test plan
- Reset then basic op, WIDTH=8: a=0xF0, b=0x3C, op=1 (OR), accepted → next cycle y=0xFC, zero=0, parity=0, out_valid=1, op_count=1.
- Backpressure: out_ready=0, result pending, in_valid=1 with new operands → in_ready=0; y holds 0xFC for 5 cycles; a new value appears only after out_ready=1.
- Streaming: out_ready=1, 4 consecutive accepts (AND, XOR, NOR, NOT A on a=0xAA, b=0x0F) → outputs 0x0A, 0xA5, 0x50, 0x55 on consecutive cycles; op_count=4.
- Flags: op=2 (XOR), a=b=0x5A → y=0x00, zero=1, parity=0. Then op=7 (PASS A), a=0x01 → zero=0, parity=1.
- Accumulator (BITWISE_ACC_EN):
  - acc_clr, then OR with b=0x01, 0x02, 0x04 with acc_sel=1 → y=0x01, 0x03, 0x07.
  - acc_clr asserted together with an accepted OR of b=0x80 → y=0x80.
- Async reset mid-stream: rst pulsed between clock edges while out_valid=1 → out_valid, y, op_count and acc go to 0 immediately; the first accept after reset release yields op_count=1.
